// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet TX path.
//   tx_state_e          : FCS controller sequencing states
//   ETH_MIN_FRAME_BYTES : minimum DA..payload length before the FCS
//   ETH_FCS_BYTES       : length of the frame check sequence
//   bitrev8 / bitrev32  : bit-order reversal between wire order and CRC register order
package ethernet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } tx_state_e;

    localparam int ETH_MIN_FRAME_BYTES = 60;
    localparam int ETH_FCS_BYTES       = 4;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// MSB-first CRC-32 engine (polynomial 0x04C11DB7, preset all-ones), one byte per clock.
//   clk_i        : clock
//   rst_n_i      : asynchronous active-low reset, presets the register
//   initialize_i : load the all-ones preset (has priority over compute_i)
//   compute_i    : fold data_i into the register this cycle
//   data_i       : byte, bit 7 processed first
//   crc32_o      : current register contents (no final inversion)
module ethernet_crc32 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        initialize_i,
    input  logic        compute_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc32_o
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (initialize_i) begin
            crc_d = '1;
        end else if (compute_i) begin
            crc_d = crc_byte(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc32_o = crc_q;

endmodule

// File: rtl/ethernet_tx_fcs_controller.sv
// TX FCS controller: passes frame bytes through, zero-pads short frames to
// MIN_FRAME_BYTES and appends the 4-byte FCS in on-wire order.
//   clk_i, rst_n_i                     : clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_last_i/s_ready_o : input byte stream from the framer
//   m_data_o/m_valid_o/m_last_o/m_ready_i : output byte stream to the PHY side
//   busy_o                             : a frame is in progress
module ethernet_tx_fcs_controller
    import ethernet_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
    parameter int PAD_ENABLE      = 1,
    parameter int CNT_WIDTH       = 11
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic       busy_o
);

    localparam logic [1:0] LAST_K = 2'(ETH_FCS_BYTES - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           k_q, k_d;

    logic        crc_init;
    logic        crc_compute;
    logic [7:0]  crc_data;
    logic [31:0] crc_reg;
    logic [31:0] fcs;
    logic [31:0] cnt_plus1;
    logic [CNT_WIDTH-1:0] cnt_sat;

    ethernet_crc32 u_crc (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .initialize_i (crc_init),
        .compute_i    (crc_compute),
        .data_i       (crc_data),
        .crc32_o      (crc_reg)
    );

    // The engine runs MSB-first on bit-reversed bytes, so reversing its register
    // gives the reflected CRC-32; inverted, its low byte goes on the wire first.
    assign fcs       = ~bitrev32(crc_reg);
    assign cnt_plus1 = 32'(cnt_q) + 32'd1;
    assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        m_last_o    = 1'b0;
        m_data_o    = 8'h00;
        crc_init    = 1'b0;
        crc_compute = 1'b0;
        crc_data    = 8'h00;
        case (state_q)
            IDLE: begin
                crc_init = 1'b1;
                // No byte is taken here; the first byte is accepted in DATA.
                if (s_valid_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_data_o  = s_data_i;
                m_valid_o = s_valid_i;
                s_ready_o = m_ready_i;
                if (s_valid_i && m_ready_i) begin
                    crc_compute = 1'b1;
                    crc_data    = bitrev8(s_data_i);
                    cnt_d       = cnt_sat;
                    if (s_last_i) begin
                        if ((PAD_ENABLE != 0) && (cnt_plus1 < 32'(MIN_FRAME_BYTES))) begin
                            state_d = PAD;
                        end else begin
                            state_d = FCS;
                        end
                    end
                end
            end
            PAD: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    crc_compute = 1'b1;
                    cnt_d       = cnt_sat;
                    if (cnt_plus1 >= 32'(MIN_FRAME_BYTES)) begin
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                m_valid_o = 1'b1;
                m_last_o  = (k_q == LAST_K);
                case (k_q)
                    2'd0:    m_data_o = fcs[7:0];
                    2'd1:    m_data_o = fcs[15:8];
                    2'd2:    m_data_o = fcs[23:16];
                    default: m_data_o = fcs[31:24];
                endcase
                if (m_ready_i) begin
                    if (k_q == LAST_K) begin
                        state_d = IDLE;
                        k_d     = 2'd0;
                        cnt_d   = '0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ethernet_tx_fcs_controller.sv
// Bench for ethernet_tx_fcs_controller: a padding and a non-padding instance share
// one input stream; each output stream is compared with a reference CRC-32 model.
module tb_ethernet_tx_fcs_controller;

    typedef logic [7:0] bq_t[$];
    typedef logic       lq_t[$];

    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b1;
    bit         rand_ready = 1'b0;

    logic       s_ready0, m_valid0, m_last0, busy0;
    logic       s_ready1, m_valid1, m_last1, busy1;
    logic [7:0] m_data0, m_data1;

    int checks = 0;
    int errors = 0;

    bq_t out0, out1;
    lq_t lst0, lst1;
    bq_t ascii;

    logic       pend0 = 1'b0, pend1 = 1'b0;
    logic [7:0] pdata0 = 8'h00, pdata1 = 8'h00;

    always #5 clk = ~clk;

    ethernet_tx_fcs_controller #(.MIN_FRAME_BYTES(60), .PAD_ENABLE(1), .CNT_WIDTH(11)) u_pad (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready0),
        .m_data_o(m_data0), .m_valid_o(m_valid0), .m_last_o(m_last0), .m_ready_i(m_ready),
        .busy_o(busy0)
    );

    ethernet_tx_fcs_controller #(.MIN_FRAME_BYTES(60), .PAD_ENABLE(0), .CNT_WIDTH(11)) u_nopad (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready1),
        .m_data_o(m_data1), .m_valid_o(m_valid1), .m_last_o(m_last1), .m_ready_i(m_ready),
        .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: optional zero padding, then reflected CRC-32 (0xEDB88320),
    // final inversion, sent least significant byte first.
    function automatic bq_t model(input bq_t in, input bit pad);
        bq_t         r;
        logic [31:0] crc;
        r = in;
        if (pad) begin
            while (r.size() < 60) r.push_back(8'h00);
        end
        crc = 32'hFFFF_FFFF;
        foreach (r[i]) begin
            crc = crc ^ 32'(r[i]);
            for (int b = 0; b < 8; b++) begin
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
            end
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) r.push_back(crc[8*i +: 8]);
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output capture plus the rule that a raised m_valid holds its byte until taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            if (pend0) begin
                chk("hold valid pad", 32'(m_valid0), 32'd1);
                chk("hold data pad", 32'(m_data0), 32'(pdata0));
            end
            if (pend1) begin
                chk("hold valid nopad", 32'(m_valid1), 32'd1);
                chk("hold data nopad", 32'(m_data1), 32'(pdata1));
            end
            pend0 = m_valid0 && !m_ready;
            pend1 = m_valid1 && !m_ready;
            pdata0 = m_data0;
            pdata1 = m_data1;
            if (m_valid0 && m_ready) begin
                out0.push_back(m_data0);
                lst0.push_back(m_last0);
            end
            if (m_valid1 && m_ready) begin
                out1.push_back(m_data1);
                lst1.push_back(m_last1);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((busy0 || busy1) && guard < LIMIT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({tag, " idle timeout"}, 32'(guard < LIMIT), 32'd1);
    endtask

    task automatic send_bytes(input bq_t b, input string tag);
        int   i = 0;
        int   guard = 0;
        logic acc;
        s_valid = 1'b1;
        s_data  = b[0];
        s_last  = (b.size() == 1);
        while (i < b.size() && guard < LIMIT) begin
            @(negedge clk);
            acc = s_ready0 && s_ready1 && s_valid;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                i++;
                if (i < b.size()) begin
                    s_data = b[i];
                    s_last = (i == b.size() - 1);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        chk({tag, " bytes accepted"}, 32'(i), 32'(b.size()));
    endtask

    task automatic cmp_frame(input string tag, input bq_t got, input lq_t gl, input bq_t exp);
        chk({tag, " length"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
            chk($sformatf("%s last%0d", tag, i), 32'(gl[i]), 32'(i == exp.size() - 1));
        end
    endtask

    task automatic run_frame(input bq_t b, input string tag);
        wait_idle({tag, " pre"});
        out0.delete(); lst0.delete();
        out1.delete(); lst1.delete();
        send_bytes(b, tag);
        wait_idle({tag, " post"});
        cmp_frame({tag, " pad"}, out0, lst0, model(b, 1'b1));
        cmp_frame({tag, " nopad"}, out1, lst1, model(b, 1'b0));
    endtask

    // Known CRC-32 check value of "123456789" is 0xCBF43926.
    task automatic check_ascii(input string tag);
        logic [7:0] tail [4];
        tail = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        chk({tag, " ascii len"}, 32'(out1.size()), 32'd13);
        if (out1.size() == 13) begin
            for (int i = 0; i < 9; i++) chk({tag, " ascii data"}, 32'(out1[i]), 32'(8'h31 + i));
            for (int i = 0; i < 4; i++) chk({tag, " ascii fcs"}, 32'(out1[9+i]), 32'(tail[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " s_ready"}, 32'({s_ready0, s_ready1}), 32'd0);
        chk({tag, " m_valid"}, 32'({m_valid0, m_valid1}), 32'd0);
        chk({tag, " m_last"}, 32'({m_last0, m_last1}), 32'd0);
        chk({tag, " m_data"}, 32'({m_data0, m_data1}), 32'd0);
        chk({tag, " busy"}, 32'({busy0, busy1}), 32'd0);
    endtask

    initial begin
        bq_t b;
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        #1 rst_n = 1'b0;
        #3 check_reset_outputs("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle after reset");

        run_frame(ascii, "ascii");
        check_ascii("ascii");

        b = '{8'hAA};
        run_frame(b, "one byte");
        chk("one byte pad count", 32'(out0.size()), 32'd64);

        b = {};
        for (int i = 0; i < 60; i++) b.push_back(8'(i));
        run_frame(b, "sixty");

        rand_ready = 1'b1;
        run_frame(ascii, "ascii stall");
        check_ascii("ascii stall");

        for (int f = 0; f < 8; f++) begin
            b = {};
            for (int i = 0; i < $urandom_range(1, 80); i++) b.push_back(8'($urandom));
            run_frame(b, $sformatf("rand%0d", f));
        end

        rand_ready = 1'b0;
        run_frame(ascii, "back to back");
        check_ascii("back to back");

        // Pulse reset while the non-padding instance shows FCS byte 1.
        wait_idle("rst pre");
        send_bytes(ascii, "rst frame");
        @(posedge clk); #2;
        chk("fcs byte1 valid", 32'(m_valid1), 32'd1);
        chk("fcs byte1 data", 32'(m_data1), 32'h39);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid fcs reset");
        @(negedge clk); #3;
        rst_n = 1'b1;
        run_frame(ascii, "after reset");
        check_ascii("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
